// File: rtl/hrange_arbiter_if.sv
// Bundle of the requester, downstream and generator-side signals of hrange_arbiter.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface hrange_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_base;
  logic [NUM_REQ*WIDTH-1:0] req_limit;
  logic [NUM_REQ*WIDTH-1:0] req_step;
  logic [NUM_REQ-1:0]       req_accept;

  logic [WIDTH-1:0]         out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_valid;
  logic                     out_wait;

  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic                     done_err;

  logic [WIDTH-1:0]         gen_base;
  logic [WIDTH-1:0]         gen_limit;
  logic [WIDTH-1:0]         gen_step;
  logic                     gen_start;
  logic                     gen_wait;
  logic                     gen_reset;
  logic [WIDTH-1:0]         gen_data;
  logic                     gen_valid;
  logic                     gen_ready;

  modport master (
    input  req_valid, req_base, req_limit, req_step,
    output req_accept,
    output out_data, out_id, out_valid,
    input  out_wait,
    output done, done_id, done_err,
    output gen_base, gen_limit, gen_step, gen_start, gen_wait, gen_reset,
    input  gen_data, gen_valid, gen_ready
  );

  modport slave (
    output req_valid, req_base, req_limit, req_step,
    input  req_accept,
    input  out_data, out_id, out_valid,
    output out_wait,
    input  done, done_id, done_err,
    input  gen_base, gen_limit, gen_step, gen_start, gen_wait, gen_reset,
    output gen_data, gen_valid, gen_ready
  );
endinterface

// File: rtl/hrange_arbiter.sv
// Round-robin arbiter sharing one hrange generator between NUM_REQ requesters.
// Optional feature: define HRANGE_ARB_STEP_CHECK_EN to reject non-terminating requests.
module hrange_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             _clock,
  input  logic             _reset_n,
  hrange_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ID_W-1:0]     r_last_grant;
  logic [ID_W-1:0]     r_owner;
  logic [ID_W-1:0]     w_grant_id;
  logic                w_hit;
  logic [WIDTH-1:0]    w_sel_base;
  logic [WIDTH-1:0]    w_sel_limit;
  logic [WIDTH-1:0]    w_sel_step;
  logic                w_bad;

  logic [WIDTH-1:0]    r_base;
  logic [WIDTH-1:0]    r_limit;
  logic [WIDTH-1:0]    r_step;
  logic                r_err;
  logic [NUM_REQ-1:0]  r_accept;

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [ID_W-1:0]     r_out_id;
  logic                r_skid_valid;
  logic [WIDTH-1:0]    r_skid_data;

  logic                r_done;
  logic [ID_W-1:0]     r_done_id;
  logic                r_done_err;
  logic                r_gen_reset;

  logic                w_beat;
  logic                w_out_free;
  logic                w_drained;
  logic                w_done_set;
  logic                w_gen_start;
  logic                w_gen_wait;

  // Round-robin: slots above last_grant win first, then wrap to slot 0.
  always_comb begin
    w_hit       = 1'b0;
    w_grant_id  = '0;
    w_sel_base  = '0;
    w_sel_limit = '0;
    w_sel_step  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hit && bus.req_valid[i] && (i > int'(r_last_grant))) begin
        w_hit       = 1'b1;
        w_grant_id  = ID_W'(i);
        w_sel_base  = bus.req_base[i*WIDTH +: WIDTH];
        w_sel_limit = bus.req_limit[i*WIDTH +: WIDTH];
        w_sel_step  = bus.req_step[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_hit && bus.req_valid[i] && (i <= int'(r_last_grant))) begin
        w_hit       = 1'b1;
        w_grant_id  = ID_W'(i);
        w_sel_base  = bus.req_base[i*WIDTH +: WIDTH];
        w_sel_limit = bus.req_limit[i*WIDTH +: WIDTH];
        w_sel_step  = bus.req_step[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef HRANGE_ARB_STEP_CHECK_EN
  assign w_bad = (w_sel_step[WIDTH-1] || (w_sel_step == '0)) &&
                 ($signed(w_sel_base) < $signed(w_sel_limit));
`else
  assign w_bad = 1'b0;
`endif

  assign w_beat     = (r_state == RUN) && bus.gen_valid;
  assign w_out_free = !r_out_valid || !bus.out_wait;
  // Output stage and skid will both be empty after this edge.
  assign w_drained  = !r_skid_valid && w_out_free && !w_beat;
  assign w_gen_wait = (r_state != START) && ((r_out_valid && bus.out_wait) || r_skid_valid);

  // A range that is already drained when gen_ready arrives finishes without
  // lingering in DRAIN, so done lands the cycle after the last value leaves.
  always_comb begin
    w_next      = r_state;
    w_gen_start = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) w_next = START;
      end
      START: begin
        w_gen_start = !r_err;
        w_next      = r_err ? DRAIN : RUN;
      end
      RUN: begin
        if (bus.gen_ready) begin
          if (w_drained) begin
            w_next     = IDLE;
            w_done_set = 1'b1;
          end else begin
            w_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_drained) begin
          w_next     = IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_base       <= '0;
      r_limit      <= '0;
      r_step       <= '0;
      r_err        <= 1'b0;
      r_accept     <= '0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_done_err   <= 1'b0;
      r_gen_reset  <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_gen_reset <= 1'b0;
      r_accept    <= '0;
      r_done      <= w_done_set;
      r_done_err  <= w_done_set && r_err;
      if (w_done_set) r_done_id <= r_owner;
      if ((r_state == IDLE) && w_hit) begin
        r_owner              <= w_grant_id;
        r_last_grant         <= w_grant_id;
        r_base               <= w_sel_base;
        r_limit              <= w_sel_limit;
        r_step               <= w_sel_step;
        r_err                <= w_bad;
        r_accept[w_grant_id] <= 1'b1;
      end
    end
  end

  // The skid entry always refills the output register ahead of any new beat.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_id     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_id     <= r_owner;
        r_skid_valid <= w_beat;
        if (w_beat) r_skid_data <= bus.gen_data;
      end else if (w_beat) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.gen_data;
        r_out_id    <= r_owner;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_beat) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= bus.gen_data;
    end
  end

  assign bus.req_accept = r_accept;
  assign bus.out_data   = r_out_data;
  assign bus.out_id     = r_out_id;
  assign bus.out_valid  = r_out_valid;
  assign bus.done       = r_done;
  assign bus.done_id    = r_done_id;
  assign bus.done_err   = r_done_err;
  assign bus.gen_base   = r_base;
  assign bus.gen_limit  = r_limit;
  assign bus.gen_step   = r_step;
  assign bus.gen_start  = w_gen_start;
  assign bus.gen_wait   = w_gen_wait;
  assign bus.gen_reset  = r_gen_reset;

endmodule

// File: tb/tb_hrange_arbiter.sv
// Directed bench for hrange_arbiter with a behavioural hrange generator model.
module tb_hrange_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int ID_W    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hrange_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  hrange_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    ._clock   (clk),
    ._reset_n (rst_n),
    .bus      (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int armIdx      = -1;
  int stallLeft   = 0;

  int beatVal[$], beatCyc[$], beatId[$];
  int accId[$], accCyc[$];
  int doneCyc[$], doneId[$], doneErr[$];
  int startCyc[$];
  int stallData[$], stallGw[$];

  // Generator model: registered valid/ready, honours gen_wait sampled at the edge.
  logic signed [WIDTH-1:0] gCur, gLimit, gStep;
  logic gRun;
  always @(posedge clk) begin
    if (bus.gen_reset) begin
      gRun          <= 1'b0;
      bus.gen_valid <= 1'b0;
      bus.gen_ready <= 1'b0;
      bus.gen_data  <= '0;
    end else begin
      bus.gen_valid <= 1'b0;
      bus.gen_ready <= 1'b0;
      if (bus.gen_start) begin
        gLimit <= bus.gen_limit;
        gStep  <= bus.gen_step;
        if ($signed(bus.gen_base) < $signed(bus.gen_limit)) begin
          bus.gen_valid <= 1'b1;
          bus.gen_data  <= bus.gen_base;
          gCur          <= bus.gen_base + bus.gen_step;
          gRun          <= 1'b1;
        end else begin
          bus.gen_ready <= 1'b1;
          gRun          <= 1'b0;
        end
      end else if (gRun && !bus.gen_wait) begin
        if (gCur < gLimit) begin
          bus.gen_valid <= 1'b1;
          bus.gen_data  <= gCur;
          gCur          <= gCur + gStep;
        end else begin
          bus.gen_ready <= 1'b1;
          gRun          <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int slot, input int base, input int limit, input int step);
    bus.req_base[slot*WIDTH +: WIDTH]  = base;
    bus.req_limit[slot*WIDTH +: WIDTH] = limit;
    bus.req_step[slot*WIDTH +: WIDTH]  = step;
    bus.req_valid[ID_W'(slot)]         = 1'b1;
  endtask

  task automatic clearLogs();
    beatVal.delete(); beatCyc.delete(); beatId.delete();
    accId.delete(); accCyc.delete();
    doneCyc.delete(); doneId.delete(); doneErr.delete();
    startCyc.delete(); stallData.delete(); stallGw.delete();
  endtask

  // One cycle: drive out_wait at the falling edge, then sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
    cycle++;
    if (armIdx >= 0 && bus.out_valid && beatVal.size() == armIdx) begin
      stallLeft = 4;
      armIdx    = -1;
    end
    if (stallLeft > 0) begin
      bus.out_wait = 1'b1;
      stallLeft--;
    end else begin
      bus.out_wait = 1'b0;
    end
    #1;
    if (bus.out_valid && !bus.out_wait) begin
      beatVal.push_back($signed(bus.out_data));
      beatCyc.push_back(cycle);
      beatId.push_back(int'(bus.out_id));
    end
    if (bus.out_valid && bus.out_wait) begin
      stallData.push_back($signed(bus.out_data));
      stallGw.push_back(int'(bus.gen_wait));
    end
    if (|bus.req_accept) begin
      checkOutput("accept_onehot", $countones(bus.req_accept), 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_accept[i]) begin
          accId.push_back(i);
          accCyc.push_back(cycle);
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    if (bus.done) begin
      doneCyc.push_back(cycle);
      doneId.push_back(int'(bus.done_id));
      doneErr.push_back(int'(bus.done_err));
    end
    if (bus.gen_start) startCyc.push_back(cycle);
  endtask

  task automatic waitDones(input int n, input int budget, input string tag);
    int left;
    left = budget;
    while (doneCyc.size() < n && left > 0) begin
      tick();
      left--;
    end
    checkOutput(tag, doneCyc.size(), n);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_accept"},    int'(bus.req_accept), 0);
    checkOutput({tag, "_out_valid"}, int'(bus.out_valid), 0);
    checkOutput({tag, "_out_data"},  int'(bus.out_data), 0);
    checkOutput({tag, "_out_id"},    int'(bus.out_id), 0);
    checkOutput({tag, "_done"},      int'(bus.done), 0);
    checkOutput({tag, "_done_err"},  int'(bus.done_err), 0);
    checkOutput({tag, "_gen_start"}, int'(bus.gen_start), 0);
    checkOutput({tag, "_gen_reset"}, int'(bus.gen_reset), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int reapplied;
    bus.req_valid = '0;
    bus.req_base  = '0;
    bus.req_limit = '0;
    bus.req_step  = '0;
    bus.out_wait  = 1'b0;
    #1 rst_n = 1'b0;

    // Reset values, with slots 1 and 3 already requesting.
    applyStimulus(1, 0, 2, 1);
    applyStimulus(3, 20, 22, 1);
    tick(); tick();
    checkResetOutputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    checkOutput("gen_reset_hold", int'(bus.gen_reset), 1);

    // Round-robin 1,3 then re-asserted 1.
    clearLogs();
    reapplied = 0;
    for (int k = 0; k < 80 && doneCyc.size() < 3; k++) begin
      tick();
      if (accId.size() == 1 && reapplied == 0) begin
        applyStimulus(1, 10, 12, 1);
        reapplied = 1;
      end
    end
    checkOutput("rr_done_count", doneCyc.size(), 3);
    if (accId.size() == 3 && doneCyc.size() == 3) begin
      checkOutput("rr_acc0", accId[0], 1);
      checkOutput("rr_acc1", accId[1], 3);
      checkOutput("rr_acc2", accId[2], 1);
      checkOutput("rr_done0", doneId[0], 1);
      checkOutput("rr_done1", doneId[1], 3);
      checkOutput("rr_done2", doneId[2], 1);
      checkOutput("rr_next_acc1", accCyc[1], doneCyc[0] + 1);
      checkOutput("rr_next_acc2", accCyc[2], doneCyc[1] + 1);
    end else begin
      checkOutput("rr_acc_count", accId.size(), 3);
    end
    checkOutput("rr_beats", beatVal.size(), 6);
    if (beatVal.size() == 6) begin
      int ev[6] = '{0, 1, 20, 21, 10, 11};
      int ei[6] = '{1, 1, 3, 3, 1, 1};
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("rr_val%0d", i), beatVal[i], ev[i]);
        checkOutput($sformatf("rr_id%0d", i), beatId[i], ei[i]);
      end
    end
    tick(); tick();

    // Single request on slot 0, (0,3,1), no stall.
    clearLogs();
    t = cycle;
    applyStimulus(0, 0, 3, 1);
    waitDones(1, 30, "single_done_count");
    tick(); tick();
    checkOutput("single_acc_cyc", (accCyc.size() > 0) ? accCyc[0] : -1, t + 1);
    checkOutput("single_start_cyc", (startCyc.size() > 0) ? startCyc[0] : -1, t + 1);
    checkOutput("single_beats", beatVal.size(), 3);
    if (beatVal.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("single_val%0d", i), beatVal[i], i);
        checkOutput($sformatf("single_cyc%0d", i), beatCyc[i], t + 3 + i);
        checkOutput($sformatf("single_id%0d", i), beatId[i], 0);
      end
    end
    if (doneCyc.size() == 1) begin
      checkOutput("single_done_cyc", doneCyc[0], t + 6);
      checkOutput("single_done_id", doneId[0], 0);
      checkOutput("single_done_err", doneErr[0], 0);
    end

    // Empty range (5,5,1) on slot 2.
    clearLogs();
    t = cycle;
    applyStimulus(2, 5, 5, 1);
    waitDones(1, 30, "empty_done_count");
    tick(); tick();
    checkOutput("empty_acc_count", accId.size(), 1);
    checkOutput("empty_beats", beatVal.size(), 0);
    if (doneCyc.size() == 1) begin
      checkOutput("empty_done_cyc", doneCyc[0], t + 3);
      checkOutput("empty_done_id", doneId[0], 2);
      checkOutput("empty_done_err", doneErr[0], 0);
    end

    // (0,10,3) with a 4-cycle stall starting on the second value.
    clearLogs();
    armIdx = 1;
    applyStimulus(0, 0, 10, 3);
    waitDones(1, 40, "stall_done_count");
    tick(); tick();
    checkOutput("stall_beats", beatVal.size(), 4);
    if (beatVal.size() == 4) begin
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("stall_val%0d", i), beatVal[i], 3 * i);
    end
    checkOutput("stall_samples", stallData.size(), 4);
    foreach (stallData[i]) begin
      checkOutput($sformatf("stall_hold%0d", i), stallData[i], 3);
      checkOutput($sformatf("stall_gen_wait%0d", i), stallGw[i], 1);
    end
    if (doneId.size() == 1) checkOutput("stall_done_id", doneId[0], 0);

`ifdef HRANGE_ARB_STEP_CHECK_EN
    // Zero step is rejected without starting the generator.
    clearLogs();
    t = cycle;
    applyStimulus(3, 0, 10, 0);
    waitDones(1, 20, "step_done_count");
    tick(); tick();
    checkOutput("step_acc_cyc", (accCyc.size() > 0) ? accCyc[0] : -1, t + 1);
    checkOutput("step_starts", startCyc.size(), 0);
    checkOutput("step_beats", beatVal.size(), 0);
    if (doneCyc.size() == 1) begin
      checkOutput("step_done_cyc", doneCyc[0], t + 3);
      checkOutput("step_done_err", doneErr[0], 1);
      checkOutput("step_done_id", doneId[0], 3);
    end
`else
    // Negative step without the check streams forever.
    clearLogs();
    t = cycle;
    applyStimulus(3, 0, 10, -1);
    repeat (12) tick();
    checkOutput("nostep_starts", startCyc.size(), 1);
    checkOutput("nostep_start_cyc", (startCyc.size() > 0) ? startCyc[0] : -1, t + 1);
    checkOutput("nostep_beats", beatVal.size(), 10);
    if (beatVal.size() == 10) begin
      checkOutput("nostep_val0", beatVal[0], 0);
      checkOutput("nostep_val9", beatVal[9], -9);
      checkOutput("nostep_id", beatId[9], 3);
    end
    checkOutput("nostep_dones", doneCyc.size(), 0);
`endif
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick();

    // Reset in the middle of a range, then a fresh request.
    clearLogs();
    applyStimulus(1, 100, 120, 1);
    repeat (6) tick();
    checkOutput("mid_busy_valid", int'(bus.out_valid), 1);
    checkOutput("mid_busy_id", int'(bus.out_id), 1);
    clearLogs();
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    tick(); tick();
    @(posedge clk); #1 rst_n = 1'b1;
    checkOutput("mid_gen_reset_rel", int'(bus.gen_reset), 1);
    tick();
    checkOutput("mid_gen_reset_hold", int'(bus.gen_reset), 1);
    tick();
    checkOutput("mid_gen_reset_clear", int'(bus.gen_reset), 0);
    repeat (4) tick();
    checkOutput("mid_no_done", doneCyc.size(), 0);
    checkOutput("mid_no_beats", beatVal.size(), 0);
    applyStimulus(0, 0, 2, 1);
    waitDones(1, 30, "mid_next_done_count");
    tick(); tick();
    checkOutput("mid_next_beats", beatVal.size(), 2);
    if (beatVal.size() == 2) begin
      checkOutput("mid_next_val0", beatVal[0], 0);
      checkOutput("mid_next_val1", beatVal[1], 1);
      checkOutput("mid_next_id", beatId[1], 0);
    end
    if (doneId.size() == 1) checkOutput("mid_next_done_id", doneId[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
